// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter that serialises single-beat register accesses from
// NUM_REQ requesters onto one shared datapath, with a ready timeout.
module regfile_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 2,
  parameter int TIMEOUT = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ready,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);

  localparam int          PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]  TO_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic             we_q;
  logic [7:0]       cnt;

  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] win_idx;
  logic             win_found;

  // Scan ptr+1, ptr+2, ... so the last-served requester is considered last.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign busy = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= PTR_W'(NUM_REQ - 1);
      win       <= '0;
      we_q      <= 1'b0;
      cnt       <= '0;
      grant     <= '0;
      ack       <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ack    <= '0;
      err    <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            win       <= win_idx;
            we_q      <= req_we[win_idx];
            mem_addr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[win_idx*DATA_W +: DATA_W];
            grant     <= NUM_REQ'(1) << win_idx;
            mem_en    <= 1'b1;
            mem_we    <= req_we[win_idx];
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_ready) begin
            if (!we_q) rdata <= mem_rdata;
            ack   <= NUM_REQ'(1) << win;
            ptr   <= win;
            state <= S_ACK;
          end else if (cnt == TO_CNT - 8'd1) begin
            // TIMEOUT-th WAIT cycle without ready: abort with err.
            err   <= 1'b1;
            ack   <= NUM_REQ'(1) << win;
            ptr   <= win;
            state <= S_ACK;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_ACK: begin
          grant <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Self-checking bench: transaction-timeline reference model checked every
// cycle, a vector table of single accesses, and hand-written corner sequences.
module tb_regfile_access_arbiter;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int DW = 2;
  localparam int TO = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    grant, ack;
  logic            err, mem_en, mem_we, mem_ready, busy;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;

  regfile_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant), .ack(ack), .err(err), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs.
  logic [N-1:0]  e_grant, e_ack;
  logic          e_err, e_mem_en, e_mem_we, e_busy;
  logic [DW-1:0] e_rdata, e_mem_wdata;
  logic [AW-1:0] e_mem_addr;

  // Transaction timeline: captured -> one issue cycle -> waiting cycles -> ack cycle.
  bit m_active, m_in_wait, m_done, m_we;
  int m_waited, m_w, m_ptr;
  int ready_delay;        // WAIT cycle on which ready rises; 0 = never
  logic [DW-1:0] cur_rdata;
  bit random_rdata;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    if (reset) begin
      e_grant = '0; e_ack = '0; e_err = 0; e_rdata = '0; e_mem_en = 0; e_mem_we = 0;
      e_mem_addr = '0; e_mem_wdata = '0; e_busy = 0;
      m_active = 0; m_ptr = N - 1;
    end else begin
      e_ack = '0; e_err = 0; e_mem_en = 0; e_mem_we = 0;
      if (!m_active) begin
        w = rr_pick(req, m_ptr);
        if (w >= 0) begin
          m_active = 1; m_in_wait = 0; m_done = 0; m_w = w; m_we = req_we[w];
          e_mem_addr  = req_addr[w*AW +: AW];
          e_mem_wdata = req_wdata[w*DW +: DW];
          e_grant = '0; e_grant[w] = 1'b1;
          e_mem_en = 1; e_mem_we = m_we; e_busy = 1;
        end
      end else if (m_done) begin
        m_active = 0; e_grant = '0; e_busy = 0;
      end else if (!m_in_wait) begin
        m_in_wait = 1; m_waited = 0;
      end else begin
        m_waited++;
        if (mem_ready || m_waited == TO) begin
          m_done = 1;
          e_ack = '0; e_ack[m_w] = 1'b1;
          e_err = !mem_ready;
          if (mem_ready && !m_we) e_rdata = mem_rdata;
          m_ptr = m_w;
        end
      end
    end
  endtask

  // mem_ready follows the chosen delay while waiting; it is noise elsewhere.
  task automatic drive_mem();
    if (m_active && m_in_wait && !m_done) begin
      mem_ready = (ready_delay != 0) && (m_waited + 1 == ready_delay);
      mem_rdata = random_rdata ? DW'($urandom) : cur_rdata;
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = DW'($urandom);
    end
  endtask

  task automatic step();
    drive_mem();
    model_edge();
    @(posedge clk);
    #1;
    check("grant", grant, e_grant);
    check("ack", ack, e_ack);
    check("err", err, e_err);
    check("rdata", rdata, e_rdata);
    check("mem_en", mem_en, e_mem_en);
    check("mem_we", mem_we, e_mem_we);
    check("mem_addr", mem_addr, e_mem_addr);
    check("mem_wdata", mem_wdata, e_mem_wdata);
    check("busy", busy, e_busy);
  endtask

  task automatic settle_idle();
    int n;
    n = 0;
    while (m_active && n < 40) begin step(); n++; end
    if (m_active) check("settle_timeout", 1, 0);
    step();
  endtask

  typedef struct {
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    int              delay;
    logic [DW-1:0]   mrdata;
    logic [N-1:0]    exp_ack;
    logic            exp_err;
    logic [DW-1:0]   exp_rdata;
    int              exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int ack_cyc[$];
    int ack_who[$];
    int cyc;

    // Single accesses from idle; ptr carries over from one row to the next.
    vecs[0] = '{4'b0100, 4'b0000, 8'b00_11_00_00, 8'b00_00_00_00, 1, 2'b10, 4'b0100, 1'b0, 2'b10, 3};
    vecs[1] = '{4'b0010, 4'b0010, 8'b00_00_01_00, 8'b00_00_01_00, 3, 2'b11, 4'b0010, 1'b0, 2'b10, 5};
    vecs[2] = '{4'b1000, 4'b0000, 8'b10_00_00_00, 8'b00_00_00_00, 0, 2'b01, 4'b1000, 1'b1, 2'b10, 9};
    vecs[3] = '{4'b1001, 4'b0000, 8'b01_00_00_10, 8'b00_00_00_00, 1, 2'b01, 4'b0001, 1'b0, 2'b01, 3};
    vecs[4] = '{4'b1001, 4'b0000, 8'b01_00_00_10, 8'b00_00_00_00, 2, 2'b11, 4'b1000, 1'b0, 2'b11, 4};
    vecs[5] = '{4'b1111, 4'b1111, 8'b11_10_01_00, 8'b01_10_11_00, 1, 2'b00, 4'b0001, 1'b0, 2'b11, 3};

    random_rdata = 0; cur_rdata = '0; ready_delay = 1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 0; mem_rdata = '0;

    // Reset, then idle with no requests.
    reset = 1; step(); step();
    reset = 0;
    step(); step();
    check("idle_busy", busy, 0);
    check("idle_grant", grant, 0);

    foreach (vecs[i]) begin
      req = vecs[i].req; req_we = vecs[i].we;
      req_addr = vecs[i].addr; req_wdata = vecs[i].wdata;
      ready_delay = vecs[i].delay; cur_rdata = vecs[i].mrdata;
      lat = 0;
      do begin step(); lat++; end while (ack == '0 && lat < 20);
      check($sformatf("vec%0d_ack", i), ack, vecs[i].exp_ack);
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      req = '0;
      settle_idle();
    end

    // Round robin with all four requesting continuously.
    reset = 1; step(); reset = 0;
    req = 4'b1111; req_we = '0; ready_delay = 1; cur_rdata = 2'b01;
    cyc = 0;
    while (ack_who.size() < 5 && cyc < 60) begin
      step(); cyc++;
      for (int i = 0; i < N; i++)
        if (ack[i]) begin ack_who.push_back(i); ack_cyc.push_back(cyc); end
    end
    check("rr_count", ack_who.size(), 5);
    for (int i = 0; i < ack_who.size(); i++) begin
      check($sformatf("rr_order%0d", i), ack_who[i], i % N);
      if (i > 0) check($sformatf("rr_spacing%0d", i), ack_cyc[i] - ack_cyc[i-1], 4);
    end
    req = '0;
    settle_idle();

    // Reset in WAIT aborts without ack; the held request is re-arbitrated.
    req = 4'b0100; req_we = '0; req_addr = 8'b00_10_00_00; ready_delay = 0;
    step(); step(); step();
    check("rst_pre_busy", busy, 1);
    reset = 1; step();
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    reset = 0; ready_delay = 1; cur_rdata = 2'b11;
    step();
    check("rst_rearb_grant", grant, 4'b0100);
    lat = 0;
    do begin step(); lat++; end while (ack == '0 && lat < 20);
    check("rst_rearb_ack", ack, 4'b0100);
    req = '0;
    settle_idle();

    // Request dropped and fields changed mid-WAIT: latched access still completes.
    req = 4'b0001; req_we = '0; req_addr = 8'b00_00_00_10; ready_delay = 3; cur_rdata = 2'b10;
    step(); step();
    req = '0; req_addr = 8'b11_11_11_01; req_we = 4'b1111;
    lat = 0;
    do begin step(); lat++; end while (ack == '0 && lat < 20);
    check("drop_ack", ack, 4'b0001);
    check("drop_addr", mem_addr, 2'b10);
    check("drop_rdata", rdata, 2'b10);
    settle_idle();

    // Randomized traffic against the model.
    random_rdata = 1;
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 99) < 2);
      for (int i = 0; i < N; i++) begin
        if (req[i] && e_ack[i]) req[i] = 1'($urandom_range(0, 1));
        else if (!req[i]) req[i] = ($urandom_range(0, 2) == 0);
      end
      req_we = N'($urandom); req_addr = (N*AW)'($urandom); req_wdata = (N*DW)'($urandom);
      step();
      if (m_active && !m_in_wait && !m_done) ready_delay = $urandom_range(0, 9);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
